// File: rtl/clock_time_ctrl.sv
// Timekeeping controller: keeps hh:mm:ss from the 1 Hz tick and runs the
// RUN -> SET_HR -> SET_MIN -> RUN set-mode sequence with blink and hourly chime.
module clock_time_ctrl #(
    parameter bit H24 = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       pm,
    output logic [1:0] mode,
    output logic       blink,
    output logic       hour_strobe
);

    // Handshake: every input is a level sampled once per clk; a high level on
    // a sampled edge is one event. Outputs change one cycle after that edge.

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2,
        MODE_BAD     = 2'd3
    } mode_e;

    localparam logic [4:0] HOUR_RST = H24 ? 5'd0 : 5'd12;

    mode_e      mode_q, mode_d;
    logic [4:0] hour_q, hour_d;
    logic [5:0] min_q, min_d;
    logic [5:0] sec_q, sec_d;
    logic       pm_q, pm_d;
    logic       blink_q, blink_d;
    logic       hour_strobe_q, hour_strobe_d;

    logic [4:0] hour_inc;
    logic       pm_inc;
    logic [5:0] min_inc;

    // Shared hour step used by both the RUN carry and the SET_HR button.
    always_comb begin
        if (H24) begin
            hour_inc = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            pm_inc   = 1'b0;
        end else begin
            hour_inc = (hour_q == 5'd12) ? 5'd1 : hour_q + 5'd1;
            pm_inc   = pm_q ^ (hour_q == 5'd11);
        end
        min_inc = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
    end

    always_comb begin
        mode_d        = mode_q;
        hour_d        = hour_q;
        min_d         = min_q;
        sec_d         = sec_q;
        pm_d          = pm_q;
        blink_d       = blink_q;
        hour_strobe_d = 1'b0;

        case (mode_q)
            MODE_RUN: begin
                blink_d = 1'b0;
                if (btn_mode) begin
                    mode_d  = MODE_SET_HR;
                    sec_d   = 6'd0;
                    blink_d = 1'b1;
                end else if (tick_1hz) begin
                    if (sec_q == 6'd59) begin
                        sec_d = 6'd0;
                        min_d = min_inc;
                        if (min_q == 6'd59) begin
                            hour_d        = hour_inc;
                            pm_d          = pm_inc;
                            hour_strobe_d = 1'b1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end
            end
            MODE_SET_HR: begin
                if (tick_1hz) blink_d = ~blink_q;
                if (btn_mode) begin
                    mode_d = MODE_SET_MIN;
                end else if (btn_inc) begin
                    hour_d = hour_inc;
                    pm_d   = pm_inc;
                end
            end
            MODE_SET_MIN: begin
                if (btn_mode) begin
                    mode_d  = MODE_RUN;
                    blink_d = 1'b0;
                end else begin
                    if (tick_1hz) blink_d = ~blink_q;
                    if (btn_inc)  min_d   = min_inc;
                end
            end
            default: begin
                // Unreachable encoding: recover to RUN, leave time alone.
                mode_d  = MODE_RUN;
                blink_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q        <= MODE_RUN;
            hour_q        <= HOUR_RST;
            min_q         <= 6'd0;
            sec_q         <= 6'd0;
            pm_q          <= 1'b0;
            blink_q       <= 1'b0;
            hour_strobe_q <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            hour_q        <= hour_d;
            min_q         <= min_d;
            sec_q         <= sec_d;
            pm_q          <= pm_d;
            blink_q       <= blink_d;
            hour_strobe_q <= hour_strobe_d;
        end
    end

    assign hour        = hour_q;
    assign min         = min_q;
    assign sec         = sec_q;
    assign pm          = pm_q;
    assign mode        = mode_q;
    assign blink       = blink_q;
    assign hour_strobe = hour_strobe_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl: a 24h and a 12h instance share stimulus and are
// checked against a seconds-of-day reference model.
module tb_clock_time_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick_1hz = 1'b0;
    logic btn_mode = 1'b0;
    logic btn_inc = 1'b0;

    logic [4:0] hour24, hour12;
    logic [5:0] min24, min12, sec24, sec12;
    logic       pm24, pm12, blink24, blink12, strobe24, strobe12;
    logic [1:0] mode24, mode12;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: time as seconds of day plus mode/blink/strobe.
    int m_t = 0;
    int m_mode = 0;
    bit m_blink = 0;
    bit m_strobe = 0;

    always #5 clk = ~clk;

    clock_time_ctrl #(.H24(1'b1)) dut24 (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .hour(hour24), .min(min24), .sec(sec24), .pm(pm24), .mode(mode24),
        .blink(blink24), .hour_strobe(strobe24)
    );

    clock_time_ctrl #(.H24(1'b0)) dut12 (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .hour(hour12), .min(min12), .sec(sec12), .pm(pm12), .mode(mode12),
        .blink(blink12), .hour_strobe(strobe12)
    );

    wire [21:0] act24 = {hour24, min24, sec24, pm24, mode24, blink24, strobe24};
    wire [21:0] act12 = {hour12, min12, sec12, pm12, mode12, blink12, strobe12};

    function automatic logic [21:0] exp_vec(input bit h24);
        int h, hh;
        bit p;
        h = m_t / 3600;
        if (h24) begin
            hh = h;
            p  = 1'b0;
        end else begin
            hh = (h % 12 == 0) ? 12 : h % 12;
            p  = (h >= 12);
        end
        return {5'(hh), 6'((m_t / 60) % 60), 6'(m_t % 60), p, 2'(m_mode), m_blink, m_strobe};
    endfunction

    task automatic model_reset();
        m_t = 0; m_mode = 0; m_blink = 0; m_strobe = 0;
    endtask

    task automatic model_step(input bit tk, input bit bm, input bit bi);
        int h, m;
        m_strobe = 0;
        case (m_mode)
            0: begin
                if (bm) begin
                    m_mode = 1; m_t = m_t - (m_t % 60); m_blink = 1;
                end else if (tk) begin
                    m_t = (m_t + 1) % 86400;
                    if (m_t % 3600 == 0) m_strobe = 1;
                end
            end
            1: begin
                if (tk) m_blink = ~m_blink;
                if (bm) m_mode = 2;
                else if (bi) begin
                    h = m_t / 3600;
                    m_t = m_t + (((h + 1) % 24) - h) * 3600;
                end
            end
            default: begin
                if (bm) begin
                    m_mode = 0; m_blink = 0;
                end else begin
                    if (tk) m_blink = ~m_blink;
                    if (bi) begin
                        m = (m_t / 60) % 60;
                        m_t = m_t + (((m + 1) % 60) - m) * 60;
                    end
                end
            end
        endcase
    endtask

    // Drives one cycle of inputs, advances the model, returns at edge + 1.
    task automatic do_cycle(input bit tk, input bit bm, input bit bi);
        tick_1hz = tk; btn_mode = bm; btn_inc = bi;
        @(posedge clk);
        model_step(tk, bm, bi);
        #1;
        tick_1hz = 0; btn_mode = 0; btn_inc = 0;
    endtask

    task automatic apply_reset();
        tick_1hz = 0; btn_mode = 0; btn_inc = 0;
        rst_n = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (act24 !== exp_vec(1)) begin
            n_fail++; $display("FAIL reset24 act=%h exp=%h", act24, exp_vec(1));
        end
        n_checks++;
        if (hour12 !== 5'd12 || pm12 !== 1'b0 || mode12 !== 2'd0 || sec12 !== 6'd0) begin
            n_fail++; $display("FAIL reset12 hour=%0d pm=%0b mode=%0d sec=%0d exp 12/0/0/0", hour12, pm12, mode12, sec12);
        end
    endtask

    task automatic test_count();
        int strobes = 0;
        int bad = 0;
        for (int i = 0; i < 3725; i++) begin
            do_cycle(1, 0, 0);
            if (strobe24) strobes++;
            if (act24 !== exp_vec(1) || act12 !== exp_vec(0)) begin
                bad++;
                if (bad < 5) $display("FAIL count tick=%0d act24=%h exp24=%h act12=%h exp12=%h",
                                      i, act24, exp_vec(1), act12, exp_vec(0));
            end
            do_cycle(0, 0, 0);
            if (strobe24 || strobe12) strobes += 10;
        end
        n_checks++;
        if (bad != 0) n_fail++;
        n_checks++;
        if ({hour24, min24, sec24, mode24, blink24} !== {5'd1, 6'd2, 6'd5, 2'd0, 1'b0}) begin
            n_fail++; $display("FAIL count_final act=%0d:%0d:%0d mode=%0d blink=%0b exp 1:2:5 0 0",
                               hour24, min24, sec24, mode24, blink24);
        end
        n_checks++;
        if (strobes != 1) begin
            n_fail++; $display("FAIL count_strobes act=%0d exp=1", strobes);
        end
    endtask

    task automatic test_rollover();
        apply_reset();
        do_cycle(0, 1, 0);
        repeat (23) do_cycle(0, 0, 1);
        do_cycle(0, 1, 0);
        repeat (59) do_cycle(0, 0, 1);
        do_cycle(0, 1, 0);
        repeat (58) do_cycle(1, 0, 0);
        n_checks++;
        if ({hour24, min24, sec24} !== {5'd23, 6'd59, 6'd58}) begin
            n_fail++; $display("FAIL preload act=%0d:%0d:%0d exp 23:59:58", hour24, min24, sec24);
        end
        do_cycle(1, 0, 0);
        n_checks++;
        if ({hour24, min24, sec24, strobe24} !== {5'd23, 6'd59, 6'd59, 1'b0}) begin
            n_fail++; $display("FAIL roll_59 act=%0d:%0d:%0d s=%0b exp 23:59:59 s=0", hour24, min24, sec24, strobe24);
        end
        do_cycle(1, 0, 0);
        n_checks++;
        if ({hour24, min24, sec24, strobe24} !== {5'd0, 6'd0, 6'd0, 1'b1}) begin
            n_fail++; $display("FAIL roll_00 act=%0d:%0d:%0d s=%0b exp 0:0:0 s=1", hour24, min24, sec24, strobe24);
        end
        n_checks++;
        if (act12 !== exp_vec(0)) begin
            n_fail++; $display("FAIL roll_12h act=%h exp=%h", act12, exp_vec(0));
        end
        do_cycle(0, 0, 0);
        n_checks++;
        if (strobe24 !== 1'b0) begin
            n_fail++; $display("FAIL roll_strobe_len act=%0b exp=0", strobe24);
        end
    endtask

    task automatic test_12h();
        apply_reset();
        do_cycle(0, 1, 0);
        repeat (11) do_cycle(0, 0, 1);
        n_checks++;
        if ({hour12, pm12} !== {5'd11, 1'b0}) begin
            n_fail++; $display("FAIL h12_11 act=%0d pm=%0b exp 11 pm=0", hour12, pm12);
        end
        do_cycle(0, 0, 1);
        n_checks++;
        if ({hour12, pm12} !== {5'd12, 1'b1}) begin
            n_fail++; $display("FAIL h12_12 act=%0d pm=%0b exp 12 pm=1", hour12, pm12);
        end
        do_cycle(0, 0, 1);
        n_checks++;
        if ({hour12, pm12, pm24} !== {5'd1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL h12_1 act=%0d pm=%0b pm24=%0b exp 1 pm=1 pm24=0", hour12, pm12, pm24);
        end
    endtask

    task automatic test_set_freeze();
        bit exp_blink[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        apply_reset();
        repeat (37) do_cycle(1, 0, 0);
        n_checks++;
        if (sec24 !== 6'd37) begin
            n_fail++; $display("FAIL pre_set sec act=%0d exp=37", sec24);
        end
        do_cycle(0, 1, 0);
        n_checks++;
        if ({mode24, sec24, blink24} !== {2'd1, 6'd0, 1'b1}) begin
            n_fail++; $display("FAIL set_entry mode=%0d sec=%0d blink=%0b exp 1/0/1", mode24, sec24, blink24);
        end
        for (int i = 0; i < 4; i++) begin
            do_cycle(1, 0, 0);
            n_checks++;
            if (blink24 !== exp_blink[i] || {hour24, min24, sec24} !== 17'd0 || act12 !== exp_vec(0)) begin
                n_fail++; $display("FAIL freeze_%0d blink=%0b time=%0d:%0d:%0d exp blink=%0b 0:0:0",
                                   i, blink24, hour24, min24, sec24, exp_blink[i]);
            end
        end
        do_cycle(0, 1, 0);
        repeat (61) do_cycle(0, 0, 1);
        n_checks++;
        if ({hour24, min24, mode24} !== {5'd0, 6'd1, 2'd2}) begin
            n_fail++; $display("FAIL min_wrap act=%0d:%0d mode=%0d exp 0:1 mode=2", hour24, min24, mode24);
        end
        do_cycle(0, 1, 0);
        n_checks++;
        if ({mode24, blink24, sec24} !== {2'd0, 1'b0, 6'd0}) begin
            n_fail++; $display("FAIL exit_set mode=%0d blink=%0b sec=%0d exp 0/0/0", mode24, blink24, sec24);
        end
        do_cycle(1, 0, 0);
        n_checks++;
        if (sec24 !== 6'd1) begin
            n_fail++; $display("FAIL resume sec act=%0d exp=1", sec24);
        end
    endtask

    task automatic test_simultaneous();
        repeat (5) do_cycle(1, 0, 0);
        do_cycle(1, 1, 0);
        n_checks++;
        if ({mode24, sec24, min24, strobe24} !== {2'd1, 6'd0, 6'd1, 1'b0}) begin
            n_fail++; $display("FAIL mode_tick mode=%0d sec=%0d min=%0d s=%0b exp 1/0/1/0", mode24, sec24, min24, strobe24);
        end
        do_cycle(0, 1, 1);
        n_checks++;
        if ({mode24, hour24} !== {2'd2, 5'd0}) begin
            n_fail++; $display("FAIL mode_inc mode=%0d hour=%0d exp 2/0", mode24, hour24);
        end
        do_cycle(1, 1, 0);
        n_checks++;
        if ({mode24, blink24, sec24} !== {2'd0, 1'b0, 6'd0}) begin
            n_fail++; $display("FAIL setmin_exit_tick mode=%0d blink=%0b sec=%0d exp 0/0/0", mode24, blink24, sec24);
        end
        do_cycle(0, 1, 0);
        do_cycle(1, 0, 1);
        n_checks++;
        if ({hour24, blink24} !== {5'd1, 1'b0} || act12 !== exp_vec(0)) begin
            n_fail++; $display("FAIL inc_tick hour=%0d blink=%0b exp 1/0", hour24, blink24);
        end
        do_cycle(0, 1, 0);
        do_cycle(0, 1, 0);
    endtask

    task automatic test_async_reset();
        apply_reset();
        do_cycle(0, 1, 0);
        do_cycle(0, 1, 0);
        repeat (30) do_cycle(0, 0, 1);
        n_checks++;
        if ({mode24, min24, blink24} !== {2'd2, 6'd30, 1'b1}) begin
            n_fail++; $display("FAIL pre_rst mode=%0d min=%0d blink=%0b exp 2/30/1", mode24, min24, blink24);
        end
        #2;
        rst_n = 0;
        model_reset();
        #1;
        n_checks++;
        if ({mode24, min24, blink24} !== {2'd0, 6'd0, 1'b0} || act12 !== exp_vec(0)) begin
            n_fail++; $display("FAIL async_rst mode=%0d min=%0d blink=%0b exp 0/0/0", mode24, min24, blink24);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        do_cycle(1, 0, 0);
        n_checks++;
        if (sec24 !== 6'd1) begin
            n_fail++; $display("FAIL post_rst sec act=%0d exp=1", sec24);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        bit tk, bm, bi;
        apply_reset();
        for (int i = 0; i < 4000; i++) begin
            tk = ($urandom_range(0, 3) == 0);
            bm = ($urandom_range(0, 24) == 0);
            bi = ($urandom_range(0, 2) == 0);
            do_cycle(tk, bm, bi);
            n_checks++;
            if (act24 !== exp_vec(1) || act12 !== exp_vec(0)) begin
                bad++;
                n_fail++;
                if (bad < 5) $display("FAIL random cyc=%0d act24=%h exp24=%h act12=%h exp12=%h",
                                      i, act24, exp_vec(1), act12, exp_vec(0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_rollover();
        test_12h();
        test_set_freeze();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
